// File: rtl/pso_pkg.sv
// Shared definitions for the PSO phase sequencer: state codes, phase bit
// indices and small helpers mapping phase states to their start bits.
package pso_pkg;

  localparam int NUM_PHASES = 5;
  localparam int PH_INIT    = 0;
  localparam int PH_FIT     = 1;
  localparam int PH_UPD     = 2;
  localparam int PH_PB      = 3;
  localparam int PH_GB      = 4;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_INIT  = 4'd1;
  localparam logic [3:0] ST_FIT   = 4'd2;
  localparam logic [3:0] ST_UPD   = 4'd3;
  localparam logic [3:0] ST_PB    = 4'd4;
  localparam logic [3:0] ST_GB    = 4'd5;
  localparam logic [3:0] ST_CHK   = 4'd6;
  localparam logic [3:0] ST_CONV  = 4'd7;
  localparam logic [3:0] ST_FAULT = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE  = ST_IDLE,
    S_INIT  = ST_INIT,
    S_FIT   = ST_FIT,
    S_UPD   = ST_UPD,
    S_PB    = ST_PB,
    S_GB    = ST_GB,
    S_CHK   = ST_CHK,
    S_CONV  = ST_CONV,
    S_FAULT = ST_FAULT
  } pso_state_e;

  // One-hot start/done bit owned by a phase state; zero for non-phase states.
  function automatic logic [NUM_PHASES-1:0] phase_mask(input pso_state_e st);
    logic [NUM_PHASES-1:0] m;
    case (st)
      S_INIT:  m = 5'b00001;
      S_FIT:   m = 5'b00010;
      S_UPD:   m = 5'b00100;
      S_PB:    m = 5'b01000;
      S_GB:    m = 5'b10000;
      default: m = 5'b00000;
    endcase
    return m;
  endfunction

  function automatic pso_state_e phase_succ(input pso_state_e st);
    pso_state_e n;
    case (st)
      S_INIT:  n = S_FIT;
      S_FIT:   n = S_UPD;
      S_UPD:   n = S_PB;
      S_PB:    n = S_GB;
      S_GB:    n = S_CHK;
      default: n = S_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/pso_phase_timer.sv
// Per-phase watchdog: cleared on phase entry, counts while a phase runs and
// flags the last permitted cycle.
module pso_phase_timer #(
  parameter int TMO_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic expire
);

  localparam int CW = $clog2(TMO_CYCLES + 1);
  localparam int LAST_I = TMO_CYCLES - 1;
  localparam logic [CW-1:0] LAST = LAST_I[CW-1:0];

  logic [CW-1:0] count_r;

  // Cycle counter, saturating at the expiry value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count_r <= '0;
    end else if (run && (count_r != LAST)) begin
      count_r <= count_r + CW'(1'b1);
    end else begin
      count_r <= count_r;
    end
  end

  // Expiry means the count would reach TMO_CYCLES at the end of this cycle.
  assign expire = run && (count_r == LAST);

endmodule

// File: rtl/pso_sequencer.sv
// Top-level phase sequencer of the PSO MPPT controller: walks the five engines,
// counts iterations, detects gbest stall and optionally re-tracks power.
module pso_sequencer
  import pso_pkg::*;
#(
  parameter int FW            = 16,
  parameter int IW            = 6,
  parameter int MAX_ITER      = 60,
  parameter int STALL_ITERS   = 4,
  parameter int EPS           = 8,
  parameter int TMO_CYCLES    = 65535,
  parameter int TRACK_EN      = 1,
  parameter int RESTART_DELTA = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic [FW-1:0]         gbest_fit,
  input  logic [FW-1:0]         meas_power,
  input  logic                  meas_valid,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic                  busy,
  output logic                  converged,
  output logic                  timeout_err,
  output logic [IW-1:0]         iter_cnt,
  output logic [3:0]            state_o
);

  localparam logic [FW:0]   EPS_W     = EPS[FW:0];
  localparam logic [FW:0]   DELTA_W   = RESTART_DELTA[FW:0];
  localparam logic [IW-1:0] MAX_W     = MAX_ITER[IW-1:0];
  localparam logic [IW-1:0] STALL_W   = STALL_ITERS[IW-1:0];
  localparam logic [IW-1:0] STALL_SAT = {IW{1'b1}};

  pso_state_e            state_r, state_nxt_s;
  logic [NUM_PHASES-1:0] start_r, mask_s;
  logic                  busy_r, converged_r, timeout_r;
  logic [IW-1:0]         iter_r, iter_nxt_s, chk_iter_s;
  logic [IW-1:0]         stall_r, stall_nxt_s, chk_stall_s;
  logic [FW-1:0]         prev_r, prev_nxt_s, hold_r, hold_nxt_s;
  logic [FW:0]           gdiff_s, mdiff_s;
  logic                  first_s, done_ok_s, expire_s;

  assign mask_s    = phase_mask(state_r);
  assign first_s   = |start_r;
  assign done_ok_s = (|(phase_done & mask_s)) && !first_s;

  pso_phase_timer #(.TMO_CYCLES(TMO_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_nxt_s != state_r),
    .run    (|mask_s),
    .expire (expire_s)
  );

  // Next-state and run-bookkeeping decisions.
  always_comb begin
    state_nxt_s = state_r;
    iter_nxt_s  = iter_r;
    stall_nxt_s = stall_r;
    prev_nxt_s  = prev_r;
    hold_nxt_s  = hold_r;

    if (gbest_fit >= prev_r) begin
      gdiff_s = {1'b0, gbest_fit} - {1'b0, prev_r};
    end else begin
      gdiff_s = {1'b0, prev_r} - {1'b0, gbest_fit};
    end
    if (meas_power >= hold_r) begin
      mdiff_s = {1'b0, meas_power} - {1'b0, hold_r};
    end else begin
      mdiff_s = {1'b0, hold_r} - {1'b0, meas_power};
    end

    chk_iter_s = iter_r + IW'(1'b1);
    // The first iteration of a run has no meaningful previous gbest.
    if ((gdiff_s <= EPS_W) && (iter_r != {IW{1'b0}})) begin
      if (stall_r != STALL_SAT) begin
        chk_stall_s = stall_r + IW'(1'b1);
      end else begin
        chk_stall_s = stall_r;
      end
    end else begin
      chk_stall_s = {IW{1'b0}};
    end

    if (state_r == S_FAULT) begin
      state_nxt_s = S_FAULT;
    end else if (!ena) begin
      state_nxt_s = S_IDLE;
      iter_nxt_s  = {IW{1'b0}};
      stall_nxt_s = {IW{1'b0}};
      prev_nxt_s  = {FW{1'b0}};
    end else begin
      case (state_r)
        S_IDLE: state_nxt_s = S_INIT;
        S_INIT, S_FIT, S_UPD, S_PB, S_GB: begin
          if (done_ok_s) begin
            state_nxt_s = phase_succ(state_r);
          end else if (expire_s) begin
            state_nxt_s = S_FAULT;
          end else begin
            state_nxt_s = state_r;
          end
        end
        S_CHK: begin
          iter_nxt_s  = chk_iter_s;
          stall_nxt_s = chk_stall_s;
          prev_nxt_s  = gbest_fit;
          if ((chk_iter_s == MAX_W) ||
              ((STALL_ITERS != 0) && (chk_stall_s == STALL_W))) begin
            state_nxt_s = S_CONV;
            hold_nxt_s  = gbest_fit;
          end else begin
            state_nxt_s = S_FIT;
          end
        end
        S_CONV: begin
          if ((TRACK_EN != 0) && meas_valid && (mdiff_s > DELTA_W)) begin
            state_nxt_s = S_INIT;
            iter_nxt_s  = {IW{1'b0}};
            stall_nxt_s = {IW{1'b0}};
            prev_nxt_s  = {FW{1'b0}};
          end else begin
            state_nxt_s = S_CONV;
          end
        end
        default: state_nxt_s = S_IDLE;
      endcase
    end
  end

  // State, registered outputs and run bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      start_r     <= 5'b00000;
      busy_r      <= 1'b0;
      converged_r <= 1'b0;
      timeout_r   <= 1'b0;
      iter_r      <= {IW{1'b0}};
      stall_r     <= {IW{1'b0}};
      prev_r      <= {FW{1'b0}};
      hold_r      <= {FW{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      start_r     <= (state_nxt_s != state_r) ? phase_mask(state_nxt_s) : 5'b00000;
      busy_r      <= !(state_nxt_s inside {S_IDLE, S_CONV, S_FAULT});
      converged_r <= (state_nxt_s == S_CONV);
      timeout_r   <= timeout_r | (state_nxt_s == S_FAULT);
      iter_r      <= iter_nxt_s;
      stall_r     <= stall_nxt_s;
      prev_r      <= prev_nxt_s;
      hold_r      <= hold_nxt_s;
    end
  end

  assign phase_start = start_r;
  assign busy        = busy_r;
  assign converged   = converged_r;
  assign timeout_err = timeout_r;
  assign iter_cnt    = iter_r;
  assign state_o     = state_r;

endmodule

// File: tb/tb_pso_sequencer.sv
// Self-checking bench for pso_sequencer: a cycle-level behavioural model is
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pso_sequencer;
  import pso_pkg::*;

  localparam int FW = 16, IW = 6, MAX_ITER = 5, STALL_ITERS = 2, EPS = 8;
  localparam int TMO = 10, TRACK_EN = 1, DELTA = 256;

  logic clk = 1'b0;
  logic reset, ena, meas_valid;
  logic [4:0] phase_done;
  logic [FW-1:0] gbest_fit, meas_power;
  logic [4:0] phase_start;
  logic busy, converged, timeout_err;
  logic [IW-1:0] iter_cnt;
  logic [3:0] state_o;

  always #5 clk = ~clk;

  pso_sequencer #(
    .FW(FW), .IW(IW), .MAX_ITER(MAX_ITER), .STALL_ITERS(STALL_ITERS), .EPS(EPS),
    .TMO_CYCLES(TMO), .TRACK_EN(TRACK_EN), .RESTART_DELTA(DELTA)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .phase_done(phase_done),
    .gbest_fit(gbest_fit), .meas_power(meas_power), .meas_valid(meas_valid),
    .phase_start(phase_start), .busy(busy), .converged(converged),
    .timeout_err(timeout_err), .iter_cnt(iter_cnt), .state_o(state_o)
  );

  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  // Behavioural model: state codes 0..8, phase states 1..5 own done bit code-1.
  int m_st = 0, m_age = 0, m_iter = 0, m_stall = 0, m_prev = 0, m_hold = 0, m_terr = 0;

  task automatic model_step();
    int nst, d;
    if (reset) begin
      m_st = 0; m_age = 0; m_iter = 0; m_stall = 0; m_prev = 0; m_hold = 0; m_terr = 0;
    end else begin
      nst = m_st;
      if (m_st == 8) begin
        nst = 8;
      end else if (!ena) begin
        nst = 0; m_iter = 0; m_stall = 0; m_prev = 0;
      end else if (m_st == 0) begin
        nst = 1;
      end else if (m_st >= 1 && m_st <= 5) begin
        if (m_age > 0 && phase_done[m_st-1]) nst = m_st + 1;
        else if (m_age + 1 >= TMO) begin nst = 8; m_terr = 1; end
      end else if (m_st == 6) begin
        d = int'(gbest_fit) - m_prev;
        if (d < 0) d = -d;
        if (d <= EPS && m_iter > 0) m_stall = (m_stall < 63) ? m_stall + 1 : 63;
        else m_stall = 0;
        m_iter = m_iter + 1;
        m_prev = int'(gbest_fit);
        if (m_iter == MAX_ITER || (STALL_ITERS != 0 && m_stall == STALL_ITERS)) begin
          nst = 7; m_hold = int'(gbest_fit);
        end else nst = 2;
      end else if (m_st == 7) begin
        d = int'(meas_power) - m_hold;
        if (d < 0) d = -d;
        if (TRACK_EN != 0 && meas_valid && d > DELTA) begin
          nst = 1; m_iter = 0; m_stall = 0; m_prev = 0;
        end
      end
      m_age = (nst == m_st) ? m_age + 1 : 0;
      m_st = nst;
    end
  endtask

  // Compare process: advance the model on each rising edge, check just after.
  initial begin
    int exp_start;
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
      #1;
      exp_start = (m_st >= 1 && m_st <= 5 && m_age == 0) ? (1 << (m_st - 1)) : 0;
      chk("state_o", state_o, m_st);
      chk("phase_start", phase_start, exp_start);
      chk("busy", busy, (m_st >= 1 && m_st <= 6) ? 1 : 0);
      chk("converged", converged, (m_st == 7) ? 1 : 0);
      chk("timeout_err", timeout_err, m_terr);
      chk("iter_cnt", iter_cnt, m_iter);
    end
  end

  // Engine responder: done 2 cycles after start; GB done also presents next gbest.
  int tmr[5];
  bit auto_resp = 1'b1, log_en = 1'b0;
  logic [4:0] hang = 5'b00000;
  int slog[$];
  int gtab[$];
  int gidx = 0;

  initial begin
    phase_done = 5'b00000;
    gbest_fit = '0;
    for (int k = 0; k < 5; k++) tmr[k] = 0;
    forever begin
      @(negedge clk);
      if (auto_resp) begin
        phase_done = 5'b00000;
        for (int k = 0; k < 5; k++) begin
          if (reset) tmr[k] = 0;
          else if (tmr[k] > 0) begin
            tmr[k]--;
            if (tmr[k] == 0) begin
              phase_done[k] = 1'b1;
              if (k == 4) begin
                if (gidx < gtab.size()) gbest_fit = FW'(gtab[gidx]);
                gidx++;
              end
            end
          end
        end
        for (int k = 0; k < 5; k++)
          if (!reset && phase_start[k] && !hang[k]) tmr[k] = 2;
      end
      if (log_en)
        for (int k = 0; k < 5; k++) if (phase_start[k]) slog.push_back(k);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_state(input int code, input int budget, input string name);
    int n = 0;
    while (int'(state_o) != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, state_o, code);
  endtask

  initial begin
    int n, c0;
    reset = 1'b1; ena = 1'b0; meas_valid = 1'b0; meas_power = '0;
    tick(3);
    chk("reset_state", state_o, 0);
    chk("reset_iter", iter_cnt, 0);
    reset = 1'b0;

    // Full run to MAX_ITER with non-stalling gbest.
    gtab.delete(); gtab.push_back(200); gtab.push_back(400); gtab.push_back(600);
    gtab.push_back(800); gtab.push_back(1000); gidx = 0;
    log_en = 1'b1; ena = 1'b1;
    wait_state(7, 400, "t1_conv");
    log_en = 1'b0;
    chk("t1_iter", iter_cnt, 5);
    chk("t1_converged", converged, 1);
    chk("t1_nstarts", slog.size(), 21);
    for (int i = 0; i < slog.size() && i < 21; i++)
      chk("t1_order", slog[i], (i == 0) ? 0 : ((i - 1) % 4) + 1);

    // Tracking: gbest_hold = 1000.
    gtab.delete(); gtab.push_back(100); gtab.push_back(200); gtab.push_back(205);
    gtab.push_back(210); gtab.push_back(300); gidx = 0;
    meas_power = 16'd1200; meas_valid = 1'b1; tick(3);
    chk("t2_hold_1200", state_o, 7);
    meas_power = 16'd1256; tick(2);
    chk("t2_hold_1256", state_o, 7);
    meas_valid = 1'b0; meas_power = 16'd700; tick(2);
    chk("t2_invalid_700", state_o, 7);
    meas_valid = 1'b1; tick(1);
    chk("t2_restart_state", state_o, 1);
    chk("t2_restart_start", phase_start, 1);
    chk("t2_restart_iter", iter_cnt, 0);
    meas_valid = 1'b0;
    wait_state(7, 400, "t2_stall_conv");
    chk("t2_stall_iter", iter_cnt, 4);

    // Stall at exactly EPS; first CHK (d=3) must not count.
    ena = 1'b0; tick(2);
    chk("t3_idle", state_o, 0);
    chk("t3_iter_clr", iter_cnt, 0);
    gtab.delete(); gtab.push_back(3); gtab.push_back(11); gtab.push_back(19); gidx = 0;
    ena = 1'b1;
    wait_state(7, 400, "t3_conv");
    chk("t3_iter", iter_cnt, 3);

    // Manual engine responses.
    ena = 1'b0; tick(2);
    auto_resp = 1'b0; phase_done = 5'b00000;
    for (int k = 0; k < 5; k++) tmr[k] = 0;
    ena = 1'b1; tick(1);
    chk("t4_init_state", state_o, 1);
    chk("t4_init_start", phase_start, 1);
    phase_done = 5'b00001; tick(1);
    chk("t4_done_in_start_ignored", state_o, 1);
    phase_done = 5'b11110; tick(1);
    chk("t4_other_done_ignored", state_o, 1);
    phase_done = 5'b00000; tick(7);
    phase_done = 5'b00001; tick(1);
    phase_done = 5'b00000;
    chk("t4_done_beats_tmo", state_o, 2);
    chk("t4_no_timeout", timeout_err, 0);
    chk("t4_fit_start", phase_start, 2);
    tick(1);
    phase_done = 5'b00010; ena = 1'b0; tick(1);
    phase_done = 5'b00000;
    chk("t4_ena_wins", state_o, 0);
    chk("t4_no_upd_start", phase_start, 0);
    tick(3);
    chk("t4_still_idle", state_o, 0);
    ena = 1'b1; tick(1);
    chk("t4_fresh_init", state_o, 1);
    chk("t4_fresh_start", phase_start, 1);
    ena = 1'b0; tick(2);
    auto_resp = 1'b1;

    // Reset in the middle of PB during the second iteration.
    ena = 1'b1;
    wait_state(6, 100, "t5_reach_chk");
    tick(1);
    wait_state(4, 100, "t5_reach_pb");
    chk("t5_iter_before", iter_cnt, 1);
    reset = 1'b1; tick(1);
    chk("t5_state", state_o, 0);
    chk("t5_start", phase_start, 0);
    chk("t5_busy", busy, 0);
    chk("t5_iter", iter_cnt, 0);
    reset = 1'b0; ena = 1'b0; tick(2);

    // UPD never answers: watchdog fault.
    hang = 5'b00100; ena = 1'b1;
    n = 0;
    while (!phase_start[2] && n < 100) begin @(negedge clk); n++; end
    chk("t6_upd_start", phase_start[2], 1);
    c0 = cyc;
    wait_state(8, 40, "t6_fault");
    chk("t6_fault_latency", cyc - c0, 10);
    chk("t6_timeout_err", timeout_err, 1);
    chk("t6_busy", busy, 0);
    ena = 1'b0; tick(3);
    chk("t6_hold_ena0", state_o, 8);
    ena = 1'b1; tick(3);
    chk("t6_hold_ena1", state_o, 8);
    reset = 1'b1; tick(1);
    chk("t6_reset_state", state_o, 0);
    chk("t6_reset_terr", timeout_err, 0);
    reset = 1'b0; ena = 1'b0; hang = 5'b00000; tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pso_sequencer.md
Name: pso_sequencer

Overview:
Parametrised top-level phase sequencer for the PSO MPPT controller. It drives the five PSO engines (init, fitness, update, pbest, gbest) through one-cycle start pulses and waits for each engine's done. It counts iterations and stops early once gbest stalls. It adds a per-phase watchdog and an optional tracking mode that re-runs the swarm when measured power departs from gbest.

Parameters:
FW, 16, fitness/power word width (unsigned)
IW, 6, iteration counter width
MAX_ITER, 60, iterations before forced convergence (1..2^IW-1)
STALL_ITERS, 4, consecutive stalled iterations that declare convergence (0 disables)
EPS, 8, max |gbest change| counted as stalled
TMO_CYCLES, 65535, per-phase watchdog limit in clk cycles
TRACK_EN, 1, 1: monitor power after convergence and restart on a change; 0: CONV is terminal
RESTART_DELTA, 256, |meas_power - gbest_hold| that triggers a restart

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ena  in  1  run enable (level)
phase_done  in  5  per-engine done pulses, bit order [0]=INIT [1]=FIT [2]=UPD [3]=PB [4]=GB
gbest_fit  in  FW  current global-best fitness from the gbest engine
meas_power  in  FW  live power sample
meas_valid  in  1  meas_power qualifier
phase_start  out  5  one-hot one-cycle start pulses, same bit order as phase_done
busy  out  1  high in any state except IDLE, CONV, FAULT
converged  out  1  high in CONV
timeout_err  out  1  sticky watchdog error
iter_cnt  out  IW  completed iterations of the current run
state_o  out  4  current state code (pso_pkg encoding)

Behaviour:
- Reset (synchronous, any state, mid-phase included): state=IDLE. phase_start=0, busy=0, converged=0, timeout_err=0, iter_cnt=0. Internal stall_cnt=0, prev_gbest=0, gbest_hold=0, watchdog=0.
- States: IDLE, INIT, FIT, UPD, PB, GB, CHK, CONV, FAULT.
- IDLE -> INIT when ena=1. Sequence: INIT -> FIT -> UPD -> PB -> GB -> CHK -> (FIT or CONV).
- Phase states:
  - The matching phase_start bit is high for exactly the first cycle in the state; all other start bits stay 0.
  - The state is left in the cycle after phase_done[k] is seen high, where k is the state's own bit.
  - phase_done[k] in the start cycle itself is ignored.
  - done bits of other phases are ignored.
- Watchdog:
  - Cleared on entry to each phase state; increments each cycle in that state.
  - When it reaches TMO_CYCLES: go to FAULT, set timeout_err=1.
  - FAULT holds until reset. ena has no effect in FAULT.
- CHK (one cycle):
  - iter_cnt += 1.
  - d = |gbest_fit - prev_gbest|, computed in FW+1 bits, no wrap. prev_gbest <= gbest_fit.
  - If d <= EPS and iter_cnt > 0 before the increment: stall_cnt += 1; otherwise stall_cnt = 0. stall_cnt saturates.
  - Next state is CONV if new iter_cnt == MAX_ITER, or if STALL_ITERS != 0 and new stall_cnt == STALL_ITERS. Otherwise FIT.
  - On going to CONV: gbest_hold <= gbest_fit.
- CONV: converged=1; iter_cnt is held.
  - TRACK_EN=1: when meas_valid=1 and |meas_power - gbest_hold| > RESTART_DELTA (FW+1-bit arithmetic), go to INIT next cycle. Clear iter_cnt, stall_cnt and prev_gbest.
  - TRACK_EN=0: CONV holds until ena falls.
- ena=0 in any state except FAULT: go to IDLE next cycle. An outstanding phase is abandoned with no further start pulse. iter_cnt, stall_cnt and prev_gbest are cleared.
- ena falling and phase_done in the same cycle: ena wins, go to IDLE.
- Watchdog expiry and phase_done in the same cycle: done wins, advance normally.

Decomposition:
- pso_pkg: state encoding localparams (4-bit), phase bit indices PH_INIT..PH_GB, NUM_PHASES=5.
- Sub-module pso_phase_timer: clear/count/expire counter sized $clog2(TMO_CYCLES+1), instantiated once.
- Absolute-difference logic stays inline.

Test Plan:
- MAX_ITER=3, STALL_ITERS=0; every engine answers done 2 cycles after its start -> start pulses in order INIT,FIT,UPD,PB,GB,FIT,... ; converged rises after the 3rd CHK; iter_cnt=3; each phase_start is 1 cycle wide.
- STALL_ITERS=2, EPS=8; gbest_fit sequence 100, 200, 205, 210 -> stall_cnt 0,0,1,2; CONV entered after the 4th CHK with iter_cnt=4.
- TMO_CYCLES=10; UPD engine never returns done -> state FAULT 10 cycles after the UPD start; timeout_err=1; ena toggling does not leave FAULT; reset clears it.
- TRACK_EN=1, RESTART_DELTA=256, gbest_hold=1000; meas_power=1200 valid -> stays in CONV; meas_power=700 valid -> INIT next cycle, INIT start pulse, iter_cnt=0.
- ena dropped in FIT in the same cycle as phase_done[1] -> IDLE next cycle, no UPD start. ena raised again -> fresh INIT start.
- reset asserted mid-PB -> next cycle all outputs at reset values, state_o=IDLE.
